// File: rtl/pattern_detector_param.sv
// Programmable sequence detector: one registered pulse per match of the last len symbols.
// Latency 1 cycle from accepting edge; no backpressure, cfg_load_i takes priority over valid_i.
module pattern_detector_param #(
  parameter int                         SYM_W       = 1,
  parameter int                         MAX_LEN     = 8,
  parameter int                         CNT_W       = 16,
  parameter int                         DEF_LEN     = 5,
  parameter logic [MAX_LEN*SYM_W-1:0]   DEF_PATTERN = 'b10110,
  localparam int                        LW          = $clog2(MAX_LEN+1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [SYM_W-1:0]           d_in,
  input  logic                       overlap_i,
  input  logic                       cfg_load_i,
  input  logic [MAX_LEN*SYM_W-1:0]   cfg_pattern_i,
  input  logic [LW-1:0]              cfg_len_i,
  output logic                       pattern_detected,
  output logic [CNT_W-1:0]           match_count_o,
  output logic [LW-1:0]              fill_o
);

  logic [MAX_LEN*SYM_W-1:0] r_hist;
  logic [MAX_LEN*SYM_W-1:0] r_pat;
  logic [LW-1:0]            r_len;
  logic [LW-1:0]            r_fill;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_det;

  logic [MAX_LEN*SYM_W-1:0] w_win;
  logic [LW:0]              w_fill_inc;
  logic [LW-1:0]            w_fill_sat;
  logic [LW-1:0]            w_cfg_len;
  logic                     w_accept;
  logic                     w_len_ok;
  logic                     w_sym_eq;
  logic                     w_match;

  // Window = history after the candidate symbol is shifted in; slot 0 is newest.
  assign w_win      = {r_hist[(MAX_LEN-1)*SYM_W-1:0], d_in};
  assign w_fill_inc = {1'b0, r_fill} + (LW+1)'(1);
  assign w_fill_sat = (w_fill_inc > (LW+1)'(MAX_LEN)) ? LW'(MAX_LEN) : w_fill_inc[LW-1:0];
  assign w_cfg_len  = (cfg_len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len_i;
  assign w_accept   = valid_i & ~cfg_load_i;
  assign w_len_ok   = (r_len != '0) && (w_fill_inc >= {1'b0, r_len});

  // Pattern symbol k (time order) lines up with window slot len-1-k.
  always_comb begin
    w_sym_eq = 1'b1;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(r_len)) begin
        if (w_win[(int'(r_len)-1-k)*SYM_W +: SYM_W] != r_pat[k*SYM_W +: SYM_W]) begin
          w_sym_eq = 1'b0;
        end
      end
    end
  end

  assign w_match = w_accept & w_len_ok & w_sym_eq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hist <= '0;
      r_pat  <= DEF_PATTERN;
      r_len  <= LW'(DEF_LEN);
      r_fill <= '0;
      r_cnt  <= '0;
      r_det  <= 1'b0;
    end else if (cfg_load_i) begin
      r_pat  <= cfg_pattern_i;
      r_len  <= w_cfg_len;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (valid_i) begin
      r_hist <= w_win;
      r_det  <= w_match;
      if (w_match) begin
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        r_fill <= overlap_i ? w_fill_sat : '0;
      end else begin
        r_fill <= w_fill_sat;
      end
    end else begin
      r_det <= 1'b0;
    end
  end

  assign pattern_detected = r_det;
  assign match_count_o    = r_cnt;
  assign fill_o           = r_fill;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Scoreboard bench for pattern_detector_param: a queue-based symbol model predicts
// pulse/count/fill for every driven cycle, compared one edge later.
module tb_pattern_detector_param;

  localparam int SYM_W   = 1;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int DEF_LEN = 5;
  localparam int LW      = 4;
  localparam logic [7:0] DEF_PAT = 8'b0001_0110;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [SYM_W-1:0]  d_in = '0;
  logic              overlap_i = 1'b0;
  logic              cfg_load_i = 1'b0;
  logic [7:0]        cfg_pattern_i = '0;
  logic [LW-1:0]     cfg_len_i = '0;
  logic              pattern_detected;
  logic [CNT_W-1:0]  match_count_o;
  logic [LW-1:0]     fill_o;

  always #5 clk = ~clk;

  pattern_detector_param #(
    .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W),
    .DEF_LEN(DEF_LEN), .DEF_PATTERN(DEF_PAT)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .d_in(d_in),
    .overlap_i(overlap_i), .cfg_load_i(cfg_load_i),
    .cfg_pattern_i(cfg_pattern_i), .cfg_len_i(cfg_len_i),
    .pattern_detected(pattern_detected), .match_count_o(match_count_o),
    .fill_o(fill_o)
  );

  typedef struct packed {
    logic        det;
    logic [31:0] cnt;
    logic [31:0] fill;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] m_pat = DEF_PAT;
  int         m_len = DEF_LEN;
  int         m_fill = 0;
  int         m_cnt = 0;
  logic       m_det = 1'b0;
  logic       m_hist[$];
  logic       ovl = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour: keep the raw symbol stream and compare its tail to the pattern.
  task automatic model(input logic rst, input logic vld, input logic d,
                       input logic ld, input logic [7:0] pat, input int len);
    bit hit;
    if (rst) begin
      m_hist.delete();
      m_pat = DEF_PAT; m_len = DEF_LEN; m_fill = 0; m_cnt = 0; m_det = 1'b0;
    end else if (ld) begin
      m_pat = pat; m_len = (len > MAX_LEN) ? MAX_LEN : len; m_fill = 0; m_det = 1'b0;
    end else if (vld) begin
      m_hist.push_back(d);
      if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
      hit = (m_len != 0) && (m_fill + 1 >= m_len) && (m_hist.size() >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - m_len + k] != m_pat[k]) hit = 1'b0;
      end
      m_det  = hit;
      m_fill = (m_fill + 1 > MAX_LEN) ? MAX_LEN : m_fill + 1;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!ovl) m_fill = 0;
      end
    end else begin
      m_det = 1'b0;
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic d,
                       input logic ld, input logic [7:0] pat, input logic [LW-1:0] len);
    exp_t e;
    @(negedge clk);
    rst_i = rst; valid_i = vld; d_in = d; overlap_i = ovl;
    cfg_load_i = ld; cfg_pattern_i = pat; cfg_len_i = len;
    model(rst, vld, d, ld, pat, int'(len));
    e.det = m_det; e.cnt = m_cnt; e.fill = m_fill;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("det", {31'd0, pattern_detected}, {31'd0, e.det});
      chk("cnt", 32'(match_count_o), e.cnt);
      chk("fill", 32'(fill_o), e.fill);
    end
  endtask

  task automatic sym(input logic d);  drive(1'b0, 1'b1, d, 1'b0, 8'h00, '0); endtask
  task automatic idle();              drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0); endtask
  task automatic do_rst();            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0); endtask
  task automatic load(input logic [7:0] p, input logic [LW-1:0] l, input logic v);
    drive(1'b0, v, 1'b1, 1'b1, p, l);
  endtask

  logic [7:0] stream = 8'b1011_0110;  // bit i = symbol i: 0,1,1,0,1,1,0,1

  initial begin
    // Overlapping detection on reset defaults
    ovl = 1'b1;
    do_rst();
    chk("rst_det", {31'd0, pattern_detected}, 32'd0);
    chk("rst_fill", 32'(fill_o), 32'd0);
    for (int i = 0; i < 8; i++) sym(stream[i]);
    chk("ovl_count", 32'(match_count_o), 32'd2);

    // Non-overlapping
    ovl = 1'b0;
    do_rst();
    for (int i = 0; i < 8; i++) sym(stream[i]);
    chk("novl_count", 32'(match_count_o), 32'd1);
    chk("novl_fill", 32'(fill_o), 32'd3);

    // Gapped valid
    ovl = 1'b1;
    do_rst();
    for (int i = 0; i < 5; i++) begin
      sym(stream[i]);
      for (int g = 0; g < 3; g++) idle();
    end
    chk("gap_count", 32'(match_count_o), 32'd1);

    // Reprogram mid-stream, simultaneous valid symbol is dropped
    do_rst();
    sym(1'b0); sym(1'b1); sym(1'b1);
    load(8'b0000_0111, 4'd3, 1'b1);
    chk("load_fill", 32'(fill_o), 32'd0);
    for (int i = 0; i < 4; i++) sym(1'b1);
    chk("reprog_count", 32'(match_count_o), 32'd2);

    // Reset aborts a partial match
    do_rst();
    sym(1'b0); sym(1'b1); sym(1'b1); sym(1'b0);
    do_rst();
    sym(1'b1);
    chk("rmid_det", {31'd0, pattern_detected}, 32'd0);
    chk("rmid_fill", 32'(fill_o), 32'd1);
    chk("rmid_count", 32'(match_count_o), 32'd0);

    // len=1 in non-overlap mode, counter saturation
    ovl = 1'b0;
    do_rst();
    load(8'h01, 4'd1, 1'b0);
    for (int i = 0; i < 6; i++) sym(1'b1);
    chk("sat_count", 32'(match_count_o), 32'd3);

    // len=0 disables detection
    ovl = 1'b1;
    load(8'h01, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) sym(1'b1);

    // Oversized length clamps to MAX_LEN: pattern 0,0,0,0,1,1,1,1
    do_rst();
    load(8'b1111_0000, 4'd15, 1'b0);
    for (int i = 0; i < 4; i++) sym(1'b0);
    for (int i = 0; i < 4; i++) sym(1'b1);
    chk("clamp_det", {31'd0, pattern_detected}, 32'd1);
    sym(1'b0);
    idle();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
